// File: rtl/octave_frame_sequencer.sv
// octave_frame_sequencer: frame-level controller feeding the first octave of the
// Gaussian/DoG pipeline. Accepts source pixels over valid/ready, forwards them
// with one cycle of latency, then injects FLUSH_ROWS rows of blanking beats so
// the octave's window and delay lines drain, and pulses frame_done.
// Optional feature macro: OCTAVE_SEQ_AUTO_RESTART_EN (DONE loops straight back
// to ACTIVE, so one start streams frames until abort).
module octave_frame_sequencer #(
  parameter int unsigned WIDTH      = 420,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned FLUSH_ROWS = 12,
  parameter int unsigned FCNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [7:0]        oct_din,
  output logic              oct_validin,
  output logic              oct_blanking,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int unsigned FLUSH_BEATS = FLUSH_ROWS * WIDTH;
  localparam int unsigned COL_W = (WIDTH > 1)       ? $clog2(WIDTH)       : 1;
  localparam int unsigned ROW_W = (HEIGHT > 1)      ? $clog2(HEIGHT)      : 1;
  localparam int unsigned FLS_W = (FLUSH_BEATS > 1) ? $clog2(FLUSH_BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [FLS_W-1:0]  r_flush;
  logic [7:0]        r_din;
  logic              r_validin;
  logic              r_blanking;
  logic              r_frame_done;
  logic [FCNT_W-1:0] r_frame_count;

  logic w_accept;
  logic w_last_col;
  logic w_last_row;
  logic w_last_flush;

  assign src_ready    = (r_state == S_ACTIVE);
  assign busy         = (r_state != S_IDLE);
  assign w_accept     = src_valid & src_ready;
  assign w_last_col   = (r_col == COL_W'(WIDTH - 1));
  assign w_last_row   = (r_row == ROW_W'(HEIGHT - 1));
  assign w_last_flush = (r_flush == FLS_W'(FLUSH_BEATS - 1));

  assign oct_din      = r_din;
  assign oct_validin  = r_validin;
  assign oct_blanking = r_blanking;
  assign frame_done   = r_frame_done;
  assign frame_count  = r_frame_count;

  // Next-state decode; abort overrides every normal transition.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_next_state = S_ACTIVE;
        S_ACTIVE: if (w_accept && w_last_col && w_last_row) w_next_state = S_FLUSH;
        S_FLUSH:  if (w_last_flush) w_next_state = S_DONE;
`ifdef OCTAVE_SEQ_AUTO_RESTART_EN
        S_DONE:   w_next_state = S_ACTIVE;
`else
        S_DONE:   w_next_state = S_IDLE;
`endif
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Column/row/flush position counters; abort discards a partial frame.
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      r_col   <= '0;
      r_row   <= '0;
      r_flush <= '0;
    end else begin
      case (r_state)
        S_ACTIVE: begin
          r_flush <= '0;
          if (w_accept) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_FLUSH: r_flush <= w_last_flush ? '0 : r_flush + 1'b1;
        default: begin
          r_col   <= '0;
          r_row   <= '0;
          r_flush <= '0;
        end
      endcase
    end
  end

  // Registered octave-side outputs, frame_done pulse and completed-frame count.
  // frame_done is raised on the FLUSH->DONE edge so it lines up with state DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_din         <= '0;
      r_validin     <= 1'b0;
      r_blanking    <= 1'b1;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_validin    <= 1'b0;
      r_frame_done <= 1'b0;
      if (abort) begin
        r_blanking <= 1'b1;
      end else begin
        case (r_state)
          S_ACTIVE: begin
            if (w_accept) begin
              r_din      <= src_data;
              r_validin  <= 1'b1;
              r_blanking <= 1'b0;
            end
          end
          S_FLUSH: begin
            r_din      <= '0;
            r_validin  <= 1'b1;
            r_blanking <= 1'b1;
            if (w_last_flush) begin
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + 1'b1;
            end
          end
          default: r_blanking <= 1'b1;
        endcase
      end
    end
  end

endmodule
